// File: rtl/uart_pkg.sv
// UART shared definitions: bit-FSM encoding and timing helpers.
// Also imported by the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  // Counter width able to hold 0 .. n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser plus 8N1 bit FSM.
// Emits single-cycle byte_ok/byte_err strobes on the stop-bit sample.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_ok_o,
  output logic       byte_err_o,
  output logic       start_o,
  output logic       active_o
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            prev_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tick_half;
  logic            tick_full;

  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);

  // Edge needs a high cycle first, so a low stop bit
  // cannot re-trigger until the line has recovered.
  assign start_o = (state_q == ST_IDLE)
                 & prev_q & ~sync2_q;

  assign byte_ok_o  = (state_q == ST_STOP)
                    & tick_full & sync2_q;
  assign byte_err_o = (state_q == ST_STOP)
                    & tick_full & ~sync2_q;
  assign active_o   = (state_q != ST_IDLE);
  assign byte_o     = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start_o) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick_half) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= sync2_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (tick_full) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (tick_full) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: pairs two bytes into {command, address}.
// Drops framing errors and stalled half-frames.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TO_CLKS = TIMEOUT_BITS * CPB;
  localparam int TW      = cnt_w(TO_CLKS);
  localparam logic [TW-1:0] TO_M1 = TW'(TO_CLKS - 1);

  logic [7:0]    rx_byte;
  logic          byte_ok;
  logic          byte_err;
  logic          start;
  logic          active;

  logic          idx_q,   idx_d;
  logic [7:0]    hold_q,  hold_d;
  logic [TW-1:0] tcnt_q,  tcnt_d;
  logic [15:0]   data_q,  data_d;
  logic          valid_q, valid_d;
  logic          err_q,   err_d;
  logic          to_q,    to_d;
  logic          busy_q,  busy_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx),
    .byte_o    (rx_byte),
    .byte_ok_o (byte_ok),
    .byte_err_o(byte_err),
    .start_o   (start),
    .active_o  (active)
  );

  always_comb begin
    idx_d   = idx_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    if (byte_ok) begin
      tcnt_d = '0;
      if (!idx_q) begin
        hold_d = rx_byte;
        idx_d  = 1'b1;
      end else begin
        data_d  = {hold_q, rx_byte};
        valid_d = 1'b1;
        idx_d   = 1'b0;
      end
    end else if (byte_err) begin
      err_d = 1'b1;
      idx_d = 1'b0;
    end else if (idx_q && !active) begin
      // A start edge on the terminal cycle still wins.
      if (start) begin
        tcnt_d = '0;
      end else if (tcnt_q == TO_M1) begin
        to_d   = 1'b1;
        idx_d  = 1'b0;
        hold_d = '0;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
    busy_d = idx_d | start
           | (active & ~byte_ok & ~byte_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 1'b0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign timeout     = to_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx.
// Scaled clock/baud so one bit is 16 clocks.
module tb_uart_frame_rx;

  localparam int CLK_FREQ = 160_000;
  localparam int BAUD     = 10_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TO_BITS  = 20;
  localparam int TO_CLKS  = TO_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nvalid = 0;
  int nerr   = 0;
  int nto    = 0;
  int nexcl  = 0;
  int to_cyc = 0;
  logic [15:0] sb[$];
  int          vstamp[$];

  uart_frame_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid) begin
      nvalid++;
      vstamp.push_back(cyc);
      if (sb.size() == 0)
        chk("sb_pop", sb.size(), 1);
      else
        chk("frame_data", frame_data,
            sb.pop_front());
    end
    if (frame_err) nerr++;
    if (timeout) begin
      nto++;
      to_cyc = cyc;
    end
    if (int'(frame_valid) + int'(frame_err)
        + int'(timeout) > 1)
      nexcl++;
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input logic       stop
  );
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1);
  end

  initial begin
    int v0, e0, t0, c0;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  frame_data,  16'h0000);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_err",   frame_err,   1'b0);
    chk("rst_to",    timeout,     1'b0);
    chk("rst_busy",  busy,        1'b0);
    rst_n = 1'b1;
    idle_bits(2);

    // T1: basic pair
    sb.push_back(16'h0305);
    send_byte(8'h03, 1'b1);
    idle_bits(1);
    send_byte(8'h05, 1'b1);
    idle_bits(2);
    chk("t1_nvalid", nvalid, 1);
    chk("t1_busy",   busy,   1'b0);
    chk("t1_sb",     sb.size(), 0);

    // T2: short low glitch is rejected
    v0 = nvalid; e0 = nerr; t0 = nto;
    rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    idle_bits(2);
    chk("t2_valid", nvalid, v0);
    chk("t2_err",   nerr,   e0);
    chk("t2_to",    nto,    t0);
    chk("t2_busy",  busy,   1'b0);

    // T3: framing error in byte 2
    v0 = nvalid; e0 = nerr;
    send_byte(8'hA1, 1'b1);
    send_byte(8'h02, 1'b0);
    idle_bits(2);
    chk("t3_err",   nerr - e0,  1);
    chk("t3_valid", nvalid, v0);
    chk("t3_data",  frame_data, 16'h0305);
    chk("t3_busy",  busy,   1'b0);

    // T4: timeout then a good frame
    t0 = nto;
    send_byte(8'h01, 1'b1);
    c0 = cyc;
    idle_bits(25);
    chk("t4_to", nto - t0, 1);
    chk("t4_to_lat",
        (to_cyc - c0 >= TO_CLKS - CPB) &&
        (to_cyc - c0 <= TO_CLKS + CPB), 1);
    chk("t4_data_kept", frame_data, 16'h0305);
    sb.push_back(16'h0107);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    idle_bits(2);
    chk("t4_sb", sb.size(), 0);

    // T5: reset during bit 4 of byte 2
    send_byte(8'h11, 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    v0 = nvalid;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_data",  frame_data,  16'h0000);
    chk("t5_valid", frame_valid, 1'b0);
    chk("t5_busy",  busy,        1'b0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    chk("t5_no_pulse", nvalid, v0);
    sb.push_back(16'h0403);
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_bits(2);
    chk("t5_sb", sb.size(), 0);

    // T6: three frames with zero idle
    vstamp.delete();
    v0 = nvalid;
    sb.push_back(16'hC3A5);
    sb.push_back(16'h00FF);
    sb.push_back(16'h5A81);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h81, 1'b1);
    idle_bits(2);
    chk("t6_nvalid", nvalid - v0, 3);
    chk("t6_sb",     sb.size(), 0);
    if (vstamp.size() == 3) begin
      chk("t6_gap1", vstamp[1] - vstamp[0],
          20 * CPB);
      chk("t6_gap2", vstamp[2] - vstamp[1],
          20 * CPB);
    end else begin
      chk("t6_stamps", vstamp.size(), 3);
    end
    chk("t6_busy", busy, 1'b0);

    chk("tot_valid", nvalid, 6);
    chk("tot_err",   nerr,   1);
    chk("tot_to",    nto,    1);
    chk("excl",      nexcl,  0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
